fft_result_serializer: RTL and testbench
========================================

# fft_result_serializer

Downstream stage of the 16-point FFT core. Captures each parallel result frame, which the core produces with no backpressure, into a two-deep ping-pong buffer. It then serializes the frame into 32-bit words on a valid/ready stream that feeds the read-channel FIFO toward the CPU. Frames that arrive while both buffers are occupied are dropped, and the drop is reported.

## Interface
- `NO_STAGES`, 4, FFT stages; `N_POINT = 2**NO_STAGES` samples per frame
- `SAMPLE_WIDTH`, 16, bits per result sample
- `OUT_WIDTH`, 32, stream word width; must be an integer multiple of `SAMPLE_WIDTH`. `SPW = OUT_WIDTH/SAMPLE_WIDTH` samples per word; `WORDS = N_POINT/SPW` words per frame.

Ports. Reset is `reset`, synchronous, active-high; clock is `clkk`.
- `clkk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `in_valid`  in  1  one-cycle strobe: `in_frame` holds a complete result frame
- `in_frame`  in  `N_POINT` x `SAMPLE_WIDTH`  result samples, index 0..N_POINT-1
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  consumer accepts the word
- `out_data`  out  `OUT_WIDTH`  packed samples
- `out_last`  out  1  marks the final word of a frame
- `overflow`  out  1  sticky: at least one frame was dropped
- `drop_cnt`  out  8  count of dropped frames, saturates at 255

## Operation
- Two frame buffers: `buf[0]` and `buf[1]`. Pointers: `wr_sel` and `rd_sel`. Occupancy: `occ`, range 0..2.
- Capture: when `in_valid=1` and `occ<2`, or `occ==2` with the final word handshaking in the same cycle, write `in_frame` to `buf[wr_sel]`, toggle `wr_sel`, and increment `occ`.
- Drop: when `in_valid=1` and `occ==2` with no final-word handshake that cycle, the frame is discarded. Set `overflow`. Increment `drop_cnt`, saturating.
- State machine, 2 states:
  - IDLE: `out_valid=0`. Go to SEND when `occ>0`.
  - SEND: `out_valid=1`. Word index `widx` counts 0..WORDS-1.
  - Handshake is `out_valid & out_ready`. On handshake with `widx<WORDS-1`, increment `widx`.
  - On handshake with `widx==WORDS-1`, which is the last word: clear `widx`, toggle `rd_sel`, decrement `occ` (net 0 if a capture happens the same cycle). Stay in SEND if the resulting `occ>0`, otherwise go to IDLE.
- Packing: word `w` = {s[SPW·w+SPW-1], …, s[SPW·w]}. The lower index occupies the lower bits. `s` is the read-order sequence described under Configuration.
- `out_data` and `out_last` are registered and update only on a handshake or on entry to SEND.
- `out_data` = 0 and `out_last` = 0 whenever `out_valid=0`.
- `out_last` = 1 exactly when `widx==WORDS-1` in SEND.
- Stream rule: once `out_valid` is asserted, it and `out_data` hold stable until the handshake.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_last` 0, `overflow` 0, `drop_cnt` 0. Also `occ` 0, `wr_sel` 0, `rd_sel` 0, `widx` 0, state IDLE.
- Reset mid-frame: all buffered data is discarded. No partial frame is emitted after reset deasserts.
- Latency: `in_valid` sampled at edge t with `occ==0` gives `out_valid=1` with word 0 from cycle t+1.
- Throughput: with `out_ready` held at 1, one word per cycle and back-to-back frames with no bubble. Frame B's word 0 follows frame A's `out_last` on the next cycle.
- Simultaneous capture and final-word handshake at `occ==2`: the frame is captured into the slot being freed and is not dropped.
- `in_valid` on consecutive cycles is legal. Each assertion is an independent frame.

## Configuration
- `FFT_BITREV_EN` defined: the read order is `s[k] = buf[rd_sel][bitrev(k)]`, where the bit reversal is over `NO_STAGES` bits. This converts the core's bit-reversed output order to natural order.
- `FFT_BITREV_EN` undefined: `s[k] = buf[rd_sel][k]`, passthrough order.
- Timing, latency and handshake behaviour are identical in both builds.

## Structure
- Shared package `fft_pkg`:
  - `NO_STAGES`, `N_POINT`, `SAMPLE_WIDTH`.
  - `sample_t` typedef and `frame_t` typedef (`sample_t [N_POINT]`).
  - `bitrev` function.
- One sub-module: `fft_word_packer`. It is combinational: frame plus word index produce the packed word, with the optional bit-reversal mux.

## Test plan
- Single frame, input s[k]=16'h0100+k, `out_ready`=1, macro off: 8 words starting 32'h0101_0100 and ending 32'h010F_010E. `out_last` is set only on word 7. First `out_valid` appears 1 cycle after `in_valid`.
- Same frame with `FFT_BITREV_EN`: word0 = 32'h0108_0100, word1 = 32'h010C_0104, word7 = 32'h010F_0107.
- Backpressure: toggle `out_ready` 1/0 every cycle. `out_data` must hold across stall cycles, all 8 words arrive in order, and frame end comes 15 cycles after the first word.
- Overflow: `out_ready`=0, then 3 frames on consecutive cycles. `overflow`=1 and `drop_cnt`=1. Frames 1 and 2 emit intact once `out_ready`=1.
- Boundary: hold `occ==2`, then assert `in_valid` in the same cycle as the last-word handshake. No drop, and 3 frames are emitted.
- Reset asserted at word 3 of a frame: all outputs return to 0. A next frame starts cleanly from word 0, and `drop_cnt`=0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, sample/frame types and the index bit-reversal helper
// used by the FFT result path.
package fft_pkg;

  localparam int NO_STAGES    = 4;
  localparam int N_POINT      = 2 ** NO_STAGES;
  localparam int SAMPLE_WIDTH = 16;

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;
  typedef sample_t frame_t [N_POINT];

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // Mirror the NO_STAGES-bit sample index (bit-reversed to natural order).
  function automatic logic [NO_STAGES-1:0] bitrev(input logic [NO_STAGES-1:0] k);
    logic [NO_STAGES-1:0] r;
    for (int b = 0; b < NO_STAGES; b++) begin
      r[b] = k[NO_STAGES-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_word_packer.sv
// Combinational packer: selects SPW samples of a frame for one stream word.
// With FFT_BITREV_EN defined, samples are fetched in bit-reversed index order.
module fft_word_packer
  import fft_pkg::*;
#(
  parameter int  OUT_WIDTH = 32,
  localparam int SPW       = OUT_WIDTH / SAMPLE_WIDTH,
  localparam int WORDS     = N_POINT / SPW,
  localparam int WIDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  frame_t                frame_i,
  input  logic [WIDX_W-1:0]     widx_i,
  output logic [OUT_WIDTH-1:0]  word_o
);

  genvar gi;
  generate
    for (gi = 0; gi < SPW; gi++) begin : g_lane
      logic [NO_STAGES-1:0] lane_idx;
      // Lower sample index lands in the lower bits of the word.
      assign lane_idx = NO_STAGES'(int'(widx_i) * SPW + gi);
`ifdef FFT_BITREV_EN
      assign word_o[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] = frame_i[bitrev(lane_idx)];
`else
      assign word_o[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] = frame_i[lane_idx];
`endif
    end
  endgenerate

endmodule

// File: rtl/fft_result_serializer.sv
// Captures FFT result frames into a ping-pong buffer and streams them as
// OUT_WIDTH-bit valid/ready words; FFT_BITREV_EN selects natural read order.
module fft_result_serializer
  import fft_pkg::*;
#(
  parameter int OUT_WIDTH = 32
) (
  input  logic                                  clkk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  input  logic [N_POINT-1:0][SAMPLE_WIDTH-1:0]  in_frame,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [OUT_WIDTH-1:0]                  out_data,
  output logic                                  out_last,
  output logic                                  overflow,
  output logic [7:0]                            drop_cnt
);

  localparam int SPW    = OUT_WIDTH / SAMPLE_WIDTH;
  localparam int WORDS  = N_POINT / SPW;
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(WORDS - 1);

  ser_state_e             state_q, state_d;
  logic [1:0]             occ_q, occ_d;
  logic                   wr_sel_q, wr_sel_d;
  logic                   rd_sel_q, rd_sel_d;
  logic [WIDX_W-1:0]      widx_q, widx_d;
  logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             drop_cnt_q, drop_cnt_d;

  frame_t                 buf_q [2];
  frame_t                 src_frame;
  logic [OUT_WIDTH-1:0]   pack_word;

  logic                   hs;
  logic                   last_hs;
  logic                   capture;
  logic                   drop;
  logic                   use_bypass;
  logic                   load;
  logic                   rd_src;
  logic [1:0]             occ_left;

  // A frame captured into an otherwise empty pipeline is sourced straight
  // from in_frame so its first word appears on the capture edge.
  genvar gi;
  generate
    for (gi = 0; gi < N_POINT; gi++) begin : g_src
      assign src_frame[gi] = use_bypass ? in_frame[gi] : buf_q[rd_src][gi];
    end
  endgenerate

  fft_word_packer #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_packer (
    .frame_i (src_frame),
    .widx_i  (widx_d),
    .word_o  (pack_word)
  );

  always_comb begin
    hs         = (state_q == ST_SEND) && out_ready;
    last_hs    = hs && (widx_q == LAST_WIDX);
    capture    = in_valid && ((occ_q != 2'd2) || last_hs);
    drop       = in_valid && !capture;
    occ_left   = occ_q - {1'b0, last_hs};
    occ_d      = occ_left + {1'b0, capture};
    use_bypass = capture && (occ_left == 2'd0);
    rd_src     = rd_sel_q ^ last_hs;
    rd_sel_d   = rd_src;
    wr_sel_d   = wr_sel_q ^ capture;
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    state_d = state_q;
    widx_d  = widx_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (occ_d != 2'd0) begin
          state_d = ST_SEND;
          widx_d  = '0;
          load    = 1'b1;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (last_hs) begin
            widx_d = '0;
            if (occ_d != 2'd0) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            widx_d = widx_q + 1'b1;
            load   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    if (load) begin
      out_data_d = pack_word;
      out_last_d = (widx_d == LAST_WIDX);
    end else if (state_d == ST_IDLE) begin
      out_data_d = '0;
      out_last_d = 1'b0;
    end
  end

  always_ff @(posedge clkk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      occ_q      <= 2'd0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      widx_q     <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      widx_q     <= widx_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Frame storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clkk) begin
    if (!reset && capture) begin
      for (int i = 0; i < N_POINT; i++) begin
        buf_q[wr_sel_q][i] <= in_frame[i];
      end
    end
  end

  assign out_valid = (state_q == ST_SEND);
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fft_result_serializer.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a frame-queue reference model of the serializer.
module tb_fft_result_serializer;

  logic              clkk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [15:0][15:0] in_frame;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic              out_last;
  logic              overflow;
  logic [7:0]        drop_cnt;

  always #5 clkk = ~clkk;

  fft_result_serializer dut (
    .clkk      (clkk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_frame  (in_frame),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [255:0] mq[$];
  int           m_widx   = 0;
  bit           m_ovf    = 1'b0;
  int           m_cnt    = 0;
  bit           chk_en   = 1'b0;
  int           dut_frames = 0;
  int           cyc      = 0;

  function automatic int rev4(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 4; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  // Expected word w of a frame: samples 2w (low half) and 2w+1 (high half).
  function automatic logic [31:0] exp_word(input logic [255:0] f, input int w);
    logic [31:0] r;
    int k;
    int src;
    r = '0;
    for (int j = 0; j < 2; j++) begin
      k = 2 * w + j;
`ifdef FFT_BITREV_EN
      src = rev4(k);
`else
      src = k;
`endif
      r[j*16 +: 16] = f[src*16 +: 16];
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 16; k++) in_frame[k] = 16'($urandom);
  endtask

  // Entered and left at a negedge: check outputs, drive inputs, advance model.
  task automatic step(input bit rst, input bit iv, input bit rdy);
    logic [31:0] ew;
    bit ev, hs, lst;
    int sz0;
    if (chk_en) begin
      ev = (mq.size() > 0);
      ew = 32'h0;
      if (ev) ew = exp_word(mq[0], m_widx);
      check_eq("out_valid", 32'(out_valid), 32'(ev));
      check_eq("out_data",  out_data, ew);
      check_eq("out_last",  32'(out_last), 32'(ev && (m_widx == 7)));
      check_eq("overflow",  32'(overflow), 32'(m_ovf));
      check_eq("drop_cnt",  32'(drop_cnt), 32'(m_cnt));
    end
    reset     = rst;
    in_valid  = iv;
    out_ready = rdy;
    if (!rst && out_valid && out_last && rdy) begin
      dut_frames++;
      $display("frame %0d delivered at cycle %0d", dut_frames, cyc);
    end
    if (rst) begin
      mq.delete();
      m_widx = 0;
      m_ovf  = 1'b0;
      m_cnt  = 0;
    end else begin
      sz0 = mq.size();
      hs  = (sz0 > 0) && rdy;
      lst = hs && (m_widx == 7);
      if (lst) begin
        void'(mq.pop_front());
        m_widx = 0;
      end else if (hs) begin
        m_widx++;
      end
      if (iv && (sz0 < 2 || lst)) begin
        mq.push_back(in_frame);
      end else if (iv) begin
        m_ovf = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    @(posedge clkk);
    cyc++;
    @(negedge clkk);
  endtask

  initial begin
    int fall;
    int f0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_frame  = '0;
    @(negedge clkk);
    step(1'b1, 1'b0, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    check_eq("rst_valid", 32'(out_valid), 32'h0);
    check_eq("rst_data",  out_data, 32'h0);
    check_eq("rst_drop",  32'(drop_cnt), 32'h0);

    // Single ramp frame, out_ready held high.
    for (int k = 0; k < 16; k++) in_frame[k] = 16'h0100 + 16'(k);
    step(1'b0, 1'b1, 1'b1);
    check_eq("f1_lat_valid", 32'(out_valid), 32'h1);
`ifdef FFT_BITREV_EN
    check_eq("f1_w0", out_data, 32'h0108_0100);
`else
    check_eq("f1_w0", out_data, 32'h0101_0100);
`endif
    step(1'b0, 1'b0, 1'b1);
`ifdef FFT_BITREV_EN
    check_eq("f1_w1", out_data, 32'h010C_0104);
`else
    check_eq("f1_w1", out_data, 32'h0103_0102);
`endif
    repeat (6) step(1'b0, 1'b0, 1'b1);
`ifdef FFT_BITREV_EN
    check_eq("f1_w7", out_data, 32'h010F_0107);
`else
    check_eq("f1_w7", out_data, 32'h010F_010E);
`endif
    check_eq("f1_last", 32'(out_last), 32'h1);
    repeat (3) step(1'b0, 1'b0, 1'b1);

    // Backpressure: out_ready alternates, starting high on word 0.
    rand_frame();
    step(1'b0, 1'b1, 1'b0);
    fall = -1;
    for (int i = 0; i < 20; i++) begin
      if (!out_valid && fall < 0) fall = i;
      step(1'b0, 1'b0, (i % 2) == 0);
    end
    check_eq("bp_frame_len", 32'(fall), 32'd15);

    // Overflow: three frames back to back while stalled.
    for (int n = 0; n < 3; n++) begin
      rand_frame();
      step(1'b0, 1'b1, 1'b0);
    end
    check_eq("ovf_flag", 32'(overflow), 32'h1);
    check_eq("ovf_cnt",  32'(drop_cnt), 32'h1);
    f0 = dut_frames;
    repeat (20) step(1'b0, 1'b0, 1'b1);
    check_eq("ovf_frames_out", 32'(dut_frames - f0), 32'd2);

    // Boundary: capture at occ==2 on the final-word handshake.
    f0 = dut_frames;
    rand_frame();
    step(1'b0, 1'b1, 1'b0);
    rand_frame();
    step(1'b0, 1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b0, 1'b1);
    rand_frame();
    step(1'b0, 1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b0, 1'b1);
    check_eq("bnd_frames_out", 32'(dut_frames - f0), 32'd3);
    check_eq("bnd_drop", 32'(drop_cnt), 32'h1);

    // Reset while word 3 of a frame is on the bus.
    rand_frame();
    step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check_eq("mrst_valid", 32'(out_valid), 32'h0);
    check_eq("mrst_data",  out_data, 32'h0);
    check_eq("mrst_last",  32'(out_last), 32'h0);
    check_eq("mrst_ovf",   32'(overflow), 32'h0);
    check_eq("mrst_drop",  32'(drop_cnt), 32'h0);
    rand_frame();
    step(1'b0, 1'b1, 1'b1);
    check_eq("mrst_next_w0", out_data, exp_word(in_frame, 0));
    repeat (10) step(1'b0, 1'b0, 1'b1);

    // Random traffic, light load with occasional resets.
    repeat (2500) begin
      rand_frame();
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0);
    end
    // Heavy load without reset to push drop_cnt into saturation.
    repeat (2200) begin
      rand_frame();
      step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 0);
    end
    check_eq("sat_cnt", 32'(drop_cnt), 32'd255);
    step(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
